// File: rtl/key_press_classifier_pkg.sv
// key_press_classifier_pkg: state encoding and event codes shared by key-handling blocks.
package key_press_classifier_pkg;
    localparam int STATE_W = 3;
    localparam int EVENT_W = 8;
    typedef enum logic [STATE_W-1:0] {
        IDLE      = 3'd0,
        PRESS     = 3'd1,
        LONG_HELD = 3'd2,
        WAIT_2ND  = 3'd3,
        PRESS_2   = 3'd4
    } state_t;
    localparam logic [1:0] EV_NONE   = 2'd0;
    localparam logic [1:0] EV_SHORT  = 2'd1;
    localparam logic [1:0] EV_LONG   = 2'd2;
    localparam logic [1:0] EV_DOUBLE = 2'd3;
endpackage

// File: rtl/key_press_classifier_if.sv
// key_press_classifier_if: key level in, classified event strobes and event count out.
interface key_press_classifier_if;
    import key_press_classifier_pkg::*;
    logic               key_in;
    logic               short_press;
    logic               long_press;
    logic               double_click;
    logic               key_held;
    logic [EVENT_W-1:0] event_cnt;
    modport master (output key_in, input short_press, long_press, double_click, key_held, event_cnt);
    modport slave  (input key_in, output short_press, long_press, double_click, key_held, event_cnt);
endinterface

// File: rtl/key_hold_timer.sv
// key_hold_timer: hold/gap counter with clear-to-1, enable and saturation; flags the long and gap limits.
// The gap flag exists only when KEY_DOUBLE_CLICK_EN is defined.
module key_hold_timer #(
    parameter int LONG_CYC    = 1000,
    parameter int DBL_GAP_CYC = 200,
    parameter int CNT_W       = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit_long
`ifdef KEY_DOUBLE_CLICK_EN
    ,
    output logic hit_gap
`endif
);
    localparam logic [CNT_W-1:0] SAT = CNT_W'(LONG_CYC > DBL_GAP_CYC ? LONG_CYC : DBL_GAP_CYC);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (clr) cnt <= CNT_W'(1);
        else if (en && cnt != SAT) cnt <= cnt + CNT_W'(1);
    end
    assign hit_long = cnt == CNT_W'(LONG_CYC - 1);
`ifdef KEY_DOUBLE_CLICK_EN
    assign hit_gap = cnt == CNT_W'(DBL_GAP_CYC);
`endif
endmodule

// File: rtl/key_press_classifier.sv
// key_press_classifier: turns a debounced key level into short/long/double-click strobes plus an event count.
// Double-click detection (gap window, second press) is built only with KEY_DOUBLE_CLICK_EN defined.
module key_press_classifier
    import key_press_classifier_pkg::*;
#(
    parameter logic ACTIVE_LVL  = 1'b0,
    parameter int   LONG_CYC    = 1000,
    parameter int   DBL_GAP_CYC = 200,
    parameter int   CNT_W       = 16
) (
    input logic clk,
    input logic rst,
    key_press_classifier_if.slave kp
);
    state_t state, nxt;
    logic act, clr, en, hit_long, sp, lp, dc;
`ifdef KEY_DOUBLE_CLICK_EN
    logic hit_gap;
`endif
    assign act = kp.key_in == ACTIVE_LVL;
    key_hold_timer #(.LONG_CYC(LONG_CYC), .DBL_GAP_CYC(DBL_GAP_CYC), .CNT_W(CNT_W)) u_timer (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .en(en),
        .hit_long(hit_long)
`ifdef KEY_DOUBLE_CLICK_EN
        ,
        .hit_gap(hit_gap)
`endif
    );
    // Release outranks the long limit; a re-press outranks gap expiry.
    always_comb begin
        nxt = state;
        clr = 1'b0;
        en  = 1'b0;
        sp  = 1'b0;
        lp  = 1'b0;
        dc  = 1'b0;
        case (state)
            IDLE: if (act) begin
                nxt = PRESS;
                clr = 1'b1;
            end
            PRESS: if (!act) begin
`ifdef KEY_DOUBLE_CLICK_EN
                nxt = WAIT_2ND;
                clr = 1'b1;
`else
                nxt = IDLE;
                sp  = 1'b1;
`endif
            end else if (hit_long) begin
                nxt = LONG_HELD;
                lp  = 1'b1;
            end else en = 1'b1;
            LONG_HELD: if (!act) nxt = IDLE;
`ifdef KEY_DOUBLE_CLICK_EN
            WAIT_2ND: if (act) nxt = PRESS_2;
            else if (hit_gap) begin
                nxt = IDLE;
                sp  = 1'b1;
            end else en = 1'b1;
            PRESS_2: if (!act) begin
                nxt = IDLE;
                dc  = 1'b1;
            end
`endif
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            kp.short_press  <= 1'b0;
            kp.long_press   <= 1'b0;
            kp.double_click <= 1'b0;
            kp.key_held     <= 1'b0;
            kp.event_cnt    <= '0;
        end else begin
            state           <= nxt;
            kp.short_press  <= sp;
            kp.long_press   <= lp;
            kp.double_click <= dc;
            kp.key_held     <= act;
            kp.event_cnt    <= kp.event_cnt + EVENT_W'(sp | lp | dc);
        end
    end
endmodule

// File: tb/tb_key_press_classifier.sv
// tb_key_press_classifier: directed stimulus, per-cycle comparison against a run-length model, plus literal checkpoints.
module tb_key_press_classifier;
    localparam int LONG_CYC = 10;
    localparam int DBL_GAP  = 4;
`ifdef KEY_DOUBLE_CLICK_EN
    localparam bit DBL_ON = 1'b1;
    localparam int SP_LAT = DBL_GAP + 1;
`else
    localparam bit DBL_ON = 1'b0;
    localparam int SP_LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    key_press_classifier_if kp();
    key_press_classifier #(.ACTIVE_LVL(1'b1), .LONG_CYC(LONG_CYC), .DBL_GAP_CYC(DBL_GAP), .CNT_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .kp(kp)
    );

    always #5 clk = ~clk;

    // Model works on press/gap run lengths rather than on states.
    typedef struct {
        int hold;
        int gap;
        bit second;
        bit pending;
        bit sp;
        bit lp;
        bit dc;
        bit held;
        int ecnt;
    } model_t;

    model_t m;

    function automatic model_t zero_model();
        model_t z;
        z.hold = 0; z.gap = 0; z.second = 0; z.pending = 0;
        z.sp = 0; z.lp = 0; z.dc = 0; z.held = 0; z.ecnt = 0;
        return z;
    endfunction

    function automatic model_t step(model_t c, bit a);
        model_t n = c;
        n.sp = 0; n.lp = 0; n.dc = 0; n.held = a;
        if (a) begin
            if (n.hold == 0) begin
                n.second  = n.pending;
                n.pending = 0;
                n.gap     = 0;
            end
            n.hold++;
            if (!n.second && n.hold == LONG_CYC) n.lp = 1;
        end else if (n.hold > 0) begin
            if (n.second) n.dc = 1;
            else if (n.hold < LONG_CYC) begin
                if (DBL_ON) begin
                    n.pending = 1;
                    n.gap     = 1;
                end else n.sp = 1;
            end
            n.hold   = 0;
            n.second = 0;
        end else if (n.pending) begin
            n.gap++;
            if (n.gap == DBL_GAP + 1) begin
                n.sp      = 1;
                n.pending = 0;
            end
        end
        n.ecnt = (c.ecnt + int'(n.sp | n.lp | n.dc)) % 256;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= zero_model();
        else m <= step(m, kp.key_in == 1'b1);
    end

    task automatic chk(input string name, input int act_v, input int exp_v);
        checks++;
        if (act_v != exp_v) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act_v, exp_v);
        end
    endtask

    always @(negedge clk) begin
        chk("model short_press", int'(kp.short_press), int'(m.sp));
        chk("model long_press", int'(kp.long_press), int'(m.lp));
        chk("model double_click", int'(kp.double_click), int'(m.dc));
        chk("model key_held", int'(kp.key_held), int'(m.held));
        chk("model event_cnt", int'(kp.event_cnt), m.ecnt);
    end

    task automatic hold(input bit v, input int n);
        kp.key_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        kp.key_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        kp.key_in = 1'b1;
        // Reset held with the key pressed
        repeat (5) @(negedge clk);
        chk("reset short_press", int'(kp.short_press), 0);
        chk("reset long_press", int'(kp.long_press), 0);
        chk("reset key_held", int'(kp.key_held), 0);
        chk("reset event_cnt", int'(kp.event_cnt), 0);
        do_reset();

        // Three-cycle short press
        hold(1, 3);
        chk("short pre-release", int'(kp.short_press), 0);
        hold(0, SP_LAT);
        chk("short strobe", int'(kp.short_press), 1);
        chk("short event_cnt", int'(kp.event_cnt), 1);
        hold(0, 1);
        chk("short one cycle", int'(kp.short_press), 0);

        // Long press of 15 cycles
        do_reset();
        hold(1, 9);
        chk("long before 10th", int'(kp.long_press), 0);
        hold(1, 1);
        chk("long strobe", int'(kp.long_press), 1);
        chk("long event_cnt", int'(kp.event_cnt), 1);
        hold(1, 5);
        hold(0, 1);
        chk("long release held", int'(kp.key_held), 0);
        hold(0, SP_LAT + 2);
        chk("long no release strobe", int'(kp.event_cnt), 1);

        // Release on the edge the long limit would be reached counts as short
        do_reset();
        hold(1, 9);
        hold(0, SP_LAT);
        chk("edge release short", int'(kp.short_press), 1);
        chk("edge release event_cnt", int'(kp.event_cnt), 1);

        // One-cycle press
        do_reset();
        hold(1, 1);
        hold(0, SP_LAT);
        chk("one cycle short", int'(kp.short_press), 1);

`ifdef KEY_DOUBLE_CLICK_EN
        // Double click
        do_reset();
        hold(1, 2); hold(0, 2); hold(1, 2);
        hold(0, 1);
        chk("double strobe", int'(kp.double_click), 1);
        hold(0, DBL_GAP + 3);
        chk("double event_cnt", int'(kp.event_cnt), 1);
        // Re-press on the same edge the gap expires
        hold(1, 2); hold(0, DBL_GAP); hold(1, 1);
        hold(0, 1);
        chk("gap edge double", int'(kp.double_click), 1);
        hold(0, DBL_GAP + 3);
        // Gap expiry
        do_reset();
        hold(1, 2);
        hold(0, DBL_GAP);
        chk("gap not yet", int'(kp.short_press), 0);
        hold(0, 1);
        chk("gap expiry short", int'(kp.short_press), 1);
`endif

        // Reset mid-press aborts silently
        do_reset();
        hold(1, 4);
        rst = 1'b1;
        @(negedge clk);
        chk("abort short_press", int'(kp.short_press), 0);
        chk("abort event_cnt", int'(kp.event_cnt), 0);
        rst = 1'b0;
        hold(0, 2);
        hold(1, 3);
        hold(0, SP_LAT);
        chk("after abort short", int'(kp.short_press), 1);
        chk("after abort event_cnt", int'(kp.event_cnt), 1);

        // Wrap of the event counter
        do_reset();
        for (int i = 0; i < 255; i++) begin
            hold(1, 2);
            hold(0, SP_LAT + 2);
        end
        chk("event_cnt 255", int'(kp.event_cnt), 255);
        hold(1, 2);
        hold(0, SP_LAT + 2);
        chk("event_cnt wrap", int'(kp.event_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
